// File: rtl/alu_md_pkg.sv
// Shared decode constants, operation codes and FSM state type for alu_control_md.
package alu_md_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;

  function automatic logic is_md_funct(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/alu_control_md_iter.sv
// md_iter: iterative multiply/divide datapath on operand magnitudes with final sign fix.
// One bit per cycle: shift-add multiply or restoring divide, sharing the hi/lo shift pair.
module md_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0]   r_hi, r_lo, r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_lo, r_neg_hi;

  logic               w_neg_a, w_neg_b, w_ge;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_diff;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod;

  assign w_neg_a = i_signed & i_a[WIDTH-1];
  assign w_neg_b = i_signed & i_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_m};
  assign w_diff  = w_shift[WIDTH-1:0] - r_m;

  // Product negates as one 2W value; quotient and remainder carry separate signs.
  assign w_prod = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign o_hi   = r_is_div ? (r_neg_hi ? -r_hi : r_hi) : w_prod[2*WIDTH-1:WIDTH];
  assign o_lo   = r_is_div ? (r_neg_lo ? -r_lo : r_lo) : w_prod[WIDTH-1:0];
  assign o_last = r_cnt == CNT_W'(WIDTH - 1);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_start) r_cnt <= '0;
    else if (i_run)   r_cnt <= r_cnt + CNT_W'(1);
  end

  // NOTE: operand/shift registers carry no reset; they are always loaded on start
  // and never observed before that, so the FSM reset alone discards any result.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_is_div <= i_is_div;
      r_neg_lo <= w_neg_a ^ w_neg_b;
      r_neg_hi <= w_neg_a;
      r_hi     <= '0;
      r_m      <= i_is_div ? w_mag_b : w_mag_a;
      r_lo     <= i_is_div ? w_mag_a : w_mag_b;
    end else if (i_run) begin
      if (r_is_div) begin
        r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decode plus iterative mult/div engine with HI/LO and stall.
// Optional ALU_MD_DIVZERO_EN: divide-by-zero is rejected in one cycle and flagged on div_zero.
module alu_control_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       operation,
  output logic             Jr,
  output logic [WIDTH-1:0] hilo_out,
  output logic             hilo_rd,
  output logic             md_stall,
  output logic             md_busy,
  output logic             md_done
`ifdef ALU_MD_DIVZERO_EN
  ,
  output logic             div_zero
`endif
);

  md_state_e        r_state;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done;

  logic             w_rtype, w_mult, w_div, w_dz, w_accept, w_idle, w_run, w_last;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  // NOTE: operation gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    operation = OP_AND;
    if (ALUOp == ALUOP_ADD)      operation = OP_ADD;
    else if (ALUOp == ALUOP_SUB) operation = OP_SUB;
    else if (ALUOp[2])           operation = ALUOp[0] ? OP_OR : OP_AND;
    else if (ALUOp[1]) begin
      case (funct)
        F_ADD:   operation = OP_ADD;
        F_SUB:   operation = OP_SUB;
        F_AND:   operation = OP_AND;
        F_OR:    operation = OP_OR;
        F_SLT:   operation = OP_SLT;
        F_SLL:   operation = OP_SLL;
        F_NOR:   operation = OP_NOR;
        F_JR:    operation = OP_ADD;
        default: operation = OP_AND;
      endcase
    end
  end

  assign Jr      = ALUOp[1] & (funct == F_JR);
  assign w_rtype = ALUOp == ALUOP_RTYPE;
  assign w_mult  = w_rtype & ((funct == F_MULT) | (funct == F_MULTU));
  assign w_div   = w_rtype & ((funct == F_DIV) | (funct == F_DIVU));
  assign w_idle  = r_state == IDLE;
  assign w_run   = r_state == RUN;

`ifdef ALU_MD_DIVZERO_EN
  assign w_dz = w_div & (src_b == '0);
`else
  assign w_dz = 1'b0;
`endif

  assign w_accept = instr_valid & w_idle & (w_mult | w_div) & ~w_dz;
  assign md_stall = instr_valid & ~w_idle & w_rtype & is_md_funct(funct);
  assign hilo_rd  = w_rtype & ((funct == F_MFHI) | (funct == F_MFLO));
  assign hilo_out = (w_rtype & (funct == F_MFHI)) ? r_hi : r_lo;
  assign md_busy  = r_busy;
  assign md_done  = r_done;

  md_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_run    (w_run),
    .i_is_div (funct[1]),
    .i_signed (~funct[0]),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_last   (w_last),
    .o_hi     (w_res_hi),
    .o_lo     (w_res_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else if (instr_valid & w_dz) begin
            r_done <= 1'b1;
          end else if (instr_valid & w_rtype & (funct == F_MTHI)) begin
            r_hi <= src_a;
          end else if (instr_valid & w_rtype & (funct == F_MTLO)) begin
            r_lo <= src_a;
          end
        end
        RUN: if (w_last) r_state <= FIX;
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_MD_DIVZERO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) div_zero <= 1'b0;
    else        div_zero <= instr_valid & w_idle & w_dz;
  end
`endif

endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md: directed cases plus random stimulus against a
// cycle-count/arithmetic reference model.
module tb_alu_control_md;

  localparam int W = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   ALUOp = 3'b000;
  logic [5:0]   funct = 6'b0;
  logic         instr_valid = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic [3:0]   operation;
  logic         Jr, hilo_rd, md_stall, md_busy, md_done;
  logic [W-1:0] hilo_out;
`ifdef ALU_MD_DIVZERO_EN
  logic         div_zero;
`endif

  alu_control_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct(funct), .instr_valid(instr_valid),
    .src_a(src_a), .src_b(src_b), .operation(operation), .Jr(Jr), .hilo_out(hilo_out),
    .hilo_rd(hilo_rd), .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done)
`ifdef ALU_MD_DIVZERO_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;
  bit           m_done = 0, m_dz = 0, m_known = 1, p_known = 1;

  function automatic logic [3:0] exp_op(input logic [2:0] aop, input logic [5:0] f);
    if (aop == 3'b000) return 4'b0010;
    if (aop == 3'b011) return 4'b0110;
    if (aop[2])        return aop[0] ? 4'b0001 : 4'b0000;
    if (aop[1]) begin
      case (f)
        6'b100000, 6'b001000: return 4'b0010;
        6'b100010: return 4'b0110;
        6'b100100: return 4'b0000;
        6'b100101: return 4'b0001;
        6'b101010: return 4'b0111;
        6'b000000: return 4'b0101;
        6'b100111: return 4'b1011;
        default:   return 4'b0000;
      endcase
    end
    return 4'b0000;
  endfunction

  function automatic bit is_md(input logic [2:0] aop, input logic [5:0] f);
    return aop == 3'b010 && f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  always @(posedge clk) begin : model
    longint sa, sb, q, r;
    bit [63:0] prod;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 0; m_dz = 0; m_known = 1;
    end else begin
      m_done = 0; m_dz = 0;
      sa = longint'($signed(src_a));
      sb = longint'($signed(src_b));
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_known = p_known; m_done = 1;
        end
      end else if (instr_valid && ALUOp == 3'b010) begin
        p_known = 1;
        case (funct)
          MULT:  begin prod = sa * sb; {p_hi, p_lo} = prod; m_left = W + 1; end
          MULTU: begin prod = {32'b0, src_a} * {32'b0, src_b}; {p_hi, p_lo} = prod; m_left = W + 1; end
          DIV, DIVU: begin
            if (src_b == 0) begin
`ifdef ALU_MD_DIVZERO_EN
              m_done = 1; m_dz = 1;
`else
              p_lo = '1; p_hi = src_a; p_known = (funct == DIVU); m_left = W + 1;
`endif
            end else begin
              if (funct == DIV) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
              else begin p_lo = src_a / src_b; p_hi = src_a % src_b; end
              m_left = W + 1;
            end
          end
          MTHI: m_hi = src_a;
          MTLO: m_lo = src_a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", md_busy, m_left > 0);
      check("done", md_done, m_done);
      check("stall", md_stall, instr_valid && m_left > 0 && is_md(ALUOp, funct));
      check("operation", operation, exp_op(ALUOp, funct));
      check("jr", Jr, ALUOp[1] && funct == 6'b001000);
      check("hilo_rd", hilo_rd, ALUOp == 3'b010 && (funct == MFHI || funct == MFLO));
      if (m_known)
        check("hilo_out", hilo_out, (ALUOp == 3'b010 && funct == MFHI) ? m_hi : m_lo);
`ifdef ALU_MD_DIVZERO_EN
      check("div_zero", div_zero, m_dz);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [2:0] aop, input logic [5:0] f, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = aop; funct = f; instr_valid = v; src_a = a; src_b = b;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nop();
    drive(3'b000, 6'b0, 1'b0, '0, '0);
  endtask

  // Issue an MD op in cycle 0 and return the cycle index at which md_done is seen.
  task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    drive(3'b010, f, 1'b1, a, b);
    tick(); nop(); n = 1;
    while (!md_done && n < 60) begin tick(); n++; end
  endtask

  task automatic read_hilo(input logic [5:0] f, input string name, input logic [W-1:0] exp);
    drive(3'b010, f, 1'b1, '0, '0); #1;
    check(name, hilo_out, exp);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 1) ? 32'($urandom_range(0, 20)) : -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] dec_f [5] = '{6'b100000, 6'b100010, 6'b101010, 6'b100111, 6'b001000};
  logic [3:0] dec_o [5] = '{4'b0010, 4'b0110, 4'b0111, 4'b1011, 4'b0010};
  logic [5:0] md_ops [4] = '{MULT, MULTU, DIV, DIVU};

  initial begin
    int n;
    logic [W-1:0] a, b;
    logic [5:0] f;
    nop();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; chk_en = 1'b1;

    // reset state
    check("rst_busy", md_busy, 1'b0);
    check("rst_done", md_done, 1'b0);
    read_hilo(MFHI, "rst_hi", 32'h0);

    // legacy decode
    for (int i = 0; i < 5; i++) begin
      drive(3'b010, dec_f[i], 1'b1, '0, '0); #1;
      check("dec_op", operation, dec_o[i]);
      check("dec_jr", Jr, i == 4);
    end
    drive(3'b101, 6'b0, 1'b1, '0, '0); #1;
    check("dec_ori", operation, 4'b0001);
    tick();

    // multu 0xFFFFFFFF * 2
    run_md(MULTU, 32'hFFFF_FFFF, 32'h2, n);
    check("multu_lat", n, 34);
    check("model_lo", m_lo, 32'hFFFF_FFFE);
    read_hilo(MFLO, "multu_lo", 32'hFFFF_FFFE);
    read_hilo(MFHI, "multu_hi", 32'h0000_0001);
    tick();

    // mult -7 * 3
    run_md(MULT, -32'd7, 32'd3, n);
    check("model_hi", m_hi, 32'hFFFF_FFFF);
    read_hilo(MFHI, "mult_hi", 32'hFFFF_FFFF);
    read_hilo(MFLO, "mult_lo", 32'hFFFF_FFEB);
    tick();

    // div -17 / 5, mflo waiting from cycle 2
    drive(3'b010, DIV, 1'b1, -32'd17, 32'd5);
    tick(); nop(); tick();
    drive(3'b010, MFLO, 1'b1, '0, '0); #1;
    check("div_stall_c2", md_stall, 1'b1);
    n = 2;
    while (md_stall && n < 60) begin tick(); n++; end
    check("div_stall_end", n, 34);
    check("div_lo", hilo_out, 32'hFFFF_FFFD);
    read_hilo(MFHI, "div_hi", 32'hFFFF_FFFE);
    tick();

    // mthi then mfhi
    drive(3'b010, MTHI, 1'b1, 32'h1234_5678, '0);
    tick();
    read_hilo(MFHI, "mthi_rd", 32'h1234_5678);
    check("mfhi_nostall", md_stall, 1'b0);
    tick();

    // reset during a divu
    drive(3'b010, DIVU, 1'b1, 32'd100, 32'd7);
    tick(); nop();
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", md_busy, 1'b0);
    read_hilo(MFHI, "rst_mid_hi", 32'h0);
    read_hilo(MFLO, "rst_mid_lo", 32'h0);
    tick();

    // divu by zero
    drive(3'b010, MTLO, 1'b1, 32'h5555_AAAA, '0); tick();
`ifdef ALU_MD_DIVZERO_EN
    drive(3'b010, DIVU, 1'b1, 32'hDEAD_BEEF, '0);
    tick(); nop();
    check("dz_done", md_done, 1'b1);
    check("dz_flag", div_zero, 1'b1);
    check("dz_busy", md_busy, 1'b0);
    read_hilo(MFLO, "dz_lo", 32'h5555_AAAA);
`else
    run_md(DIVU, 32'hDEAD_BEEF, '0, n);
    check("dz_lat", n, 34);
    read_hilo(MFLO, "dz_lo", 32'hFFFF_FFFF);
    read_hilo(MFHI, "dz_hi", 32'hDEAD_BEEF);
`endif
    tick();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      a = rnd_operand();
      b = rnd_operand();
      case ($urandom_range(0, 9))
        0, 1: drive(3'($urandom_range(0, 7)), 6'($urandom), 1'b0, a, b);
        2, 3: drive(3'($urandom_range(0, 7)), 6'($urandom), 1'($urandom_range(0, 1)), a, b);
        4:    drive(3'b010, $urandom_range(0, 1) ? MTHI : MTLO, 1'b1, a, b);
        5:    drive(3'b010, $urandom_range(0, 1) ? MFHI : MFLO, 1'b1, a, b);
        6, 7: begin
          f = md_ops[$urandom_range(0, 3)];
          drive(3'b010, f, $urandom_range(0, 4) != 0, a, b);
        end
        default: ;
      endcase
      if (ALUOp == 3'b010 && funct == DIV && src_b == '0) src_b = 32'h1;
      tick();
    end

    nop();
    repeat (40) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
